// File: rtl/uart_nn_pkg.sv
// Shared definitions for the UART-to-neural-network byte path.
//   BYTE_W  : width of one received UART byte
//   state_t : word assembler FSM states (IDLE / COLLECT)
//   clog2   : ceiling log2 helper for sizing pointers and counters
package uart_nn_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/uart_word_assembler_sync_fifo.sv
// sync_fifo: first-word-fall-through word FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, wr_data : write request and data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   rd_data    : head entry, valid whenever empty is low
//   full, empty, count : occupancy status
// The storage array is read asynchronously so that a word written on an edge
// is presented at the head on that same edge, with no bypass path from wr_data.
module sync_fifo
   import uart_nn_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [clog2(DEPTH):0]    count
);

   localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
   localparam int CNT_W = clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   assign full  = (count_reg == CNT_W'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;

   // A push into a full FIFO still succeeds if the head leaves on the same edge.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign rd_data = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_word_assembler.sv
// uart_word_assembler: packs received UART bytes little-endian into
// BYTES_PER_WORD-byte words and buffers them in a FIFO with valid/ready output.
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx_data, rx_done : byte from the UART receiver and its 1-cycle strobe
//   word_out, word_valid, word_ready : output word handshake (FIFO head)
//   fifo_count  : words held
//   overflow    : sticky, a completed word was dropped because the FIFO was full
//   rx_abort    : 1-cycle pulse when a partial word is discarded on timeout
// Optional feature macro RX_TIMEOUT_EN: enables the inter-byte timeout that
// discards a stalled partial word after TIMEOUT_CLKS clocks.
module uart_word_assembler
   import uart_nn_pkg::*;
#(
   parameter int BYTES_PER_WORD = 2,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CLKS   = 65535
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [7:0]                         rx_data,
   input  logic                               rx_done,
   output logic [8*BYTES_PER_WORD-1:0]        word_out,
   output logic                               word_valid,
   input  logic                               word_ready,
   output logic [clog2(FIFO_DEPTH):0]         fifo_count,
   output logic                               overflow,
   output logic                               rx_abort
);

   localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
   localparam int IDX_W  = (BYTES_PER_WORD > 1) ? clog2(BYTES_PER_WORD) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

   state_t            state_reg, state_next;
   logic [IDX_W-1:0]  index_reg, index_next;
   logic [WORD_W-1:0] shift_reg, shift_next;
   logic [WORD_W-1:0] assembled;
   logic              overflow_reg;
   logic              rx_abort_reg, abort_next;
   logic              push;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [WORD_W-1:0] fifo_head;

   // The incoming byte drops into the lane selected by the current index;
   // the completed word is therefore available combinationally on the last byte.
   for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign assembled[BYTE_W*gi +: BYTE_W] =
         (index_reg == IDX_W'(gi)) ? rx_data : shift_reg[BYTE_W*gi +: BYTE_W];
   end

`ifdef RX_TIMEOUT_EN
   logic [15:0] timer_reg, timer_next;
   logic        expired;

   assign expired = (state_reg == COLLECT) && !rx_done &&
                    (timer_reg == 16'(TIMEOUT_CLKS - 1));

   always_comb begin
      timer_next = '0;
      if (state_reg == COLLECT && !rx_done && !expired) begin
         timer_next = timer_reg + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_reg <= '0;
      end else begin
         timer_reg <= timer_next;
      end
   end
`else
   logic [15:0] unused_timeout;
   assign unused_timeout = 16'(TIMEOUT_CLKS);
`endif

   always_comb begin
      state_next = state_reg;
      index_next = index_reg;
      shift_next = shift_reg;
      push       = 1'b0;
      abort_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rx_done) begin
               shift_next = assembled;
               if (BYTES_PER_WORD == 1) begin
                  push = 1'b1;
               end else begin
                  index_next = IDX_W'(1);
                  state_next = COLLECT;
               end
            end
         end
         COLLECT: begin
            if (rx_done) begin
               shift_next = assembled;
               if (index_reg == LAST_IDX) begin
                  push       = 1'b1;
                  index_next = '0;
                  state_next = IDLE;
               end else begin
                  index_next = index_reg + IDX_W'(1);
               end
            end
`ifdef RX_TIMEOUT_EN
            else if (expired) begin
               index_next = '0;
               state_next = IDLE;
               abort_next = 1'b1;
            end
`endif
         end
         default: begin
            state_next = IDLE;
            index_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         index_reg    <= '0;
         shift_reg    <= '0;
         overflow_reg <= 1'b0;
         rx_abort_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         index_reg    <= index_next;
         shift_reg    <= shift_next;
         rx_abort_reg <= abort_next;
         // Dropped only when full and the head is not leaving this edge.
         if (push && fifo_full && !pop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign pop = word_valid && word_ready;

   sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .wr_data (assembled),
      .pop     (pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Head storage is not reset, so the output is forced to zero while empty.
   assign word_valid = !fifo_empty;
   assign word_out   = word_valid ? fifo_head : '0;
   assign overflow   = overflow_reg;
   assign rx_abort   = rx_abort_reg;

endmodule
